shift_out_serializer: RTL and testbench
=======================================

Name: shift_out_serializer

Overview:
- Parallel-in/serial-out shifter: the transmit end of the team's serial-in shift register.
- Accepts a BITS-wide word over a valid/ready load handshake and emits it MSB first, one bit per i_en strobe.
- Bit timing matches the serial-in shift register: tie o_dat to its i_dat, drive both blocks with the same i_en gated by o_dat_valid, and the receiver holds the word after BITS strobes.

Parameters:
- BITS, 32, word width in bits. Minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- i_sclr  input  1  synchronous active-high clear
- i_en  input  1  bit strobe; one bit consumed per cycle when high in SHIFT
- i_load_valid  input  1  i_data holds a word to send
- i_data  input  BITS  parallel word; bit BITS-1 is sent first
- o_load_ready  output  1  block can accept a word this cycle
- o_dat  output  1  current serial bit
- o_dat_valid  output  1  o_dat carries a live bit
- o_last  output  1  o_dat is the final bit of the current word
- o_busy  output  1  a word is in flight or buffered

Behaviour:
- Interface (fixed): single clock clk; i_sclr is synchronous and active-high, sampled only on posedge clk.
- Internal state:
  - shift register sh[BITS-1:0]
  - down-counter cnt, width $clog2(BITS)
  - FSM state {IDLE, SHIFT}
- Reset (i_sclr=1): state IDLE, sh=0, cnt=0, and any buffered word dropped. Next cycle: o_dat=0, o_dat_valid=0, o_last=0, o_busy=0, o_load_ready=1.
- i_sclr overrides every other input on the same edge, including mid-word. The partial word is discarded with no further bits.
- Outputs are combinational from registers only; no combinational path from any input to any output:
  - o_dat = sh[BITS-1]
  - o_dat_valid = (state==SHIFT)
  - o_last = (state==SHIFT && cnt==0)
  - o_busy = (state==SHIFT) or buffer full
- Load: accepted at a posedge where i_load_valid && o_load_ready. Then sh <= i_data, cnt <= BITS-1, state <= SHIFT. The first bit is visible the cycle after acceptance (1-cycle latency).
- IDLE:
  - o_load_ready=1.
  - i_en is ignored.
  - i_data is don't-care when i_load_valid=0.
- SHIFT with i_en=1:
  - The bit on o_dat this cycle counts as transmitted.
  - If cnt!=0: sh <= {sh[BITS-2:0],1'b0}, cnt <= cnt-1.
  - If cnt==0: word complete; go to IDLE (or reload, see Optional Feature).
- SHIFT with i_en=0: sh, cnt and outputs hold. Gaps between strobes are unlimited.
- One word is exactly BITS strobes; o_last is high for exactly the final strobe.
- Back-to-back without the optional feature: o_load_ready=0 throughout SHIFT. After the last bit there is one IDLE cycle before a new word can be accepted, so the next word's first bit appears 2 cycles after the last strobe.
- i_load_valid may stay asserted while o_load_ready=0; the word is taken at the first ready cycle. The source must hold i_data stable until acceptance.

Optional Feature:
- Macro: SHIFT_OUT_SERIALIZER_SKID_EN.
- Defined: a one-word holding buffer (BITS data + full flag) is added.
  - o_load_ready = !buf_full in any state.
  - A word accepted in IDLE with the buffer empty goes straight to sh.
  - A word accepted in SHIFT goes to the buffer.
  - On the final strobe (cnt==0, i_en=1) with the buffer full: sh <= buffer, cnt <= BITS-1, buffer emptied, state stays SHIFT. The next word's MSB follows the last bit with zero idle cycles.
  - Final strobe with the buffer empty and a load accepted the same edge: the word bypasses into sh and the block stays SHIFT.
  - i_sclr also clears buf_full.
- Undefined: no buffer; behaviour exactly as in Behaviour.

Test Plan:
- BITS=8, reset then load 8'hA5, i_en=1 every cycle -> o_dat sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles; o_last high only on the 8th; o_load_ready returns 1 the cycle after.
- BITS=32, loopback into the serial-in shift register with shared i_en & o_dat_valid, load 32'hDEADBEEF -> receiver output reads 32'hDEADBEEF after 32 strobes.
- BITS=8, load 8'h81, i_en pattern 1,0,0,1,1,0,1... -> o_dat and cnt hold on i_en=0 cycles; exactly 8 strobes complete the word; the MSB and LSB are both 1.
- BITS=8, load 8'hFF, assert i_sclr after 3 strobes -> next cycle o_dat_valid=0, o_dat=0, o_busy=0, o_load_ready=1; no further bits.
- Macro undefined, i_load_valid held with 8'h3C then 8'hC3 -> second word accepted only in the IDLE cycle; exactly one idle cycle between o_last and the next o_dat_valid.
- Macro defined, 8'h3C then 8'hC3 offered back-to-back -> 16 contiguous valid bits 0011110011000011; o_load_ready low only while the buffer is full.

Source files
------------

// File: rtl/shift_out_serializer.sv
// Parallel-in/serial-out shifter, MSB first, one bit per i_en strobe.
// Define SHIFT_OUT_SERIALIZER_SKID_EN to add a one-word holding buffer.
module shift_out_serializer #(
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            i_sclr,
   input  logic            i_en,
   input  logic            i_load_valid,
   input  logic [BITS-1:0] i_data,
   output logic            o_load_ready,
   output logic            o_dat,
   output logic            o_dat_valid,
   output logic            o_last,
   output logic            o_busy
);

   localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(BITS - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state;
   state_t          state_nx;
   logic [BITS-1:0] sh;
   logic [CW-1:0]   cnt;
   logic            ready;
   logic            load_acc;
   logic            fin;
   logic            hold_full;
   logic            reload;
   logic            bypass;

   assign load_acc = i_load_valid && ready;
   assign fin      = (state == SHIFT) && i_en && (cnt == '0);

`ifdef SHIFT_OUT_SERIALIZER_SKID_EN
   logic [BITS-1:0] hold_q;

   assign ready  = !hold_full;
   assign reload = fin && hold_full;
   assign bypass = fin && !hold_full && load_acc;

   // Words arriving mid-word park here until the final strobe.
   always_ff @(posedge clk) begin
      if (i_sclr) begin
         hold_full <= 1'b0;
      end else if (state == SHIFT && load_acc && !fin) begin
         hold_q    <= i_data;
         hold_full <= 1'b1;
      end else if (reload) begin
         hold_full <= 1'b0;
      end
   end
`else
   assign ready     = (state == IDLE);
   assign hold_full = 1'b0;
   assign reload    = 1'b0;
   assign bypass    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (i_sclr) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (load_acc) begin
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (fin && !reload && !bypass) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      o_load_ready = ready;
      o_dat        = sh[BITS-1];
      o_dat_valid  = (state == SHIFT);
      o_last       = (state == SHIFT) && (cnt == '0);
      o_busy       = (state == SHIFT) || hold_full;
   end

   always_ff @(posedge clk) begin
      if (i_sclr) begin
         sh  <= '0;
         cnt <= '0;
      end else if ((state == IDLE && load_acc) || bypass) begin
         sh  <= i_data;
         cnt <= CNT_TOP;
      end else if (reload) begin
`ifdef SHIFT_OUT_SERIALIZER_SKID_EN
         sh  <= hold_q;
`endif
         cnt <= CNT_TOP;
      end else if (state == SHIFT && i_en && cnt != '0) begin
         sh  <= {sh[BITS-2:0], 1'b0};
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_shift_out_serializer.sv
// Directed bench for shift_out_serializer: 8-bit unit plus a
// 32-bit unit looped into a behavioural serial-in receiver.
module tb_shift_out_serializer;

   logic       clk = 1'b0;
   int         n_cmp = 0;
   int         n_bad = 0;

   logic       sclr_a, en_a, lv_a;
   logic [7:0] data_a;
   logic       rdy_a, dat_a, dv_a, last_a, busy_a;

   logic        sclr_b, en_b, lv_b;
   logic [31:0] data_b;
   logic        rdy_b, dat_b, dv_b, last_b, busy_b;
   logic [31:0] rx_b;

   always #5 clk = ~clk;

   shift_out_serializer #(.BITS(8)) u_a (
      .clk          (clk),
      .i_sclr       (sclr_a),
      .i_en         (en_a),
      .i_load_valid (lv_a),
      .i_data       (data_a),
      .o_load_ready (rdy_a),
      .o_dat        (dat_a),
      .o_dat_valid  (dv_a),
      .o_last       (last_a),
      .o_busy       (busy_a)
   );

   shift_out_serializer #(.BITS(32)) u_b (
      .clk          (clk),
      .i_sclr       (sclr_b),
      .i_en         (en_b),
      .i_load_valid (lv_b),
      .i_data       (data_b),
      .o_load_ready (rdy_b),
      .o_dat        (dat_b),
      .o_dat_valid  (dv_b),
      .o_last       (last_b),
      .o_busy       (busy_b)
   );

   // Serial-in receiver sharing the gated strobe.
   always_ff @(posedge clk) begin
      if (sclr_b) begin
         rx_b <= '0;
      end else if (en_b && dv_b) begin
         rx_b <= {rx_b[30:0], dat_b};
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_a();
      sclr_a = 1'b1;
      tick();
      sclr_a = 1'b0;
   endtask

   task automatic load_a(input logic [7:0] w);
      lv_a   = 1'b1;
      data_a = w;
      tick();
      lv_a   = 1'b0;
   endtask

   initial begin
      logic [7:0]  w;
      logic [15:0] pat;
      logic [7:0]  w1;
      logic [7:0]  w2;
      int          k;
      int          strobes;
      int          got_n;

      sclr_a = 1'b0; en_a = 1'b0; lv_a = 1'b0; data_a = '0;
      sclr_b = 1'b0; en_b = 1'b0; lv_b = 1'b0; data_b = '0;
      #2;

      // Reset state
      reset_a();
      chk("rst_dat", 32'(dat_a), 32'd0);
      chk("rst_dv", 32'(dv_a), 32'd0);
      chk("rst_last", 32'(last_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_rdy", 32'(rdy_a), 32'd1);

      // A5, strobe every cycle
      w = 8'hA5;
      load_a(w);
      en_a = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("a5_dat%0d", i), 32'(dat_a), 32'(w[7-i]));
         chk($sformatf("a5_dv%0d", i), 32'(dv_a), 32'd1);
         chk($sformatf("a5_last%0d", i), 32'(last_a), 32'(i == 7));
         tick();
      end
      chk("a5_rdy_after", 32'(rdy_a), 32'd1);
      chk("a5_dv_after", 32'(dv_a), 32'd0);
      en_a = 1'b0;

      // 81 with gapped strobes
      w   = 8'h81;
      pat = 16'b1001101_1001101_10;
      load_a(w);
      strobes = 0;
      k = 0;
      while (strobes < 8 && k < 40) begin
         en_a = pat[15 - (k % 16)];
         chk($sformatf("81_dat%0d", k), 32'(dat_a), 32'(w[7-strobes]));
         chk($sformatf("81_last%0d", k), 32'(last_a), 32'(strobes == 7));
         if (en_a) strobes++;
         tick();
         k++;
      end
      chk("81_strobes", 32'(strobes), 32'd8);
      chk("81_done_dv", 32'(dv_a), 32'd0);
      en_a = 1'b0;

      // Clear mid-word
      load_a(8'hFF);
      en_a = 1'b1;
      tick(); tick(); tick();
      chk("clr_pre_dv", 32'(dv_a), 32'd1);
      sclr_a = 1'b1;
      tick();
      sclr_a = 1'b0;
      chk("clr_dv", 32'(dv_a), 32'd0);
      chk("clr_dat", 32'(dat_a), 32'd0);
      chk("clr_busy", 32'(busy_a), 32'd0);
      chk("clr_rdy", 32'(rdy_a), 32'd1);
      tick(); tick();
      chk("clr_nobits", 32'(dv_a), 32'd0);
      en_a = 1'b0;

      // Back-to-back 3C then C3 with load held
      w1 = 8'h3C;
      w2 = 8'hC3;
      en_a   = 1'b1;
      lv_a   = 1'b1;
      data_a = w1;
      tick();
      data_a = w2;
`ifdef SHIFT_OUT_SERIALIZER_SKID_EN
      for (int j = 1; j <= 16; j++) begin
         if (j == 2) lv_a = 1'b0;
         chk($sformatf("skid_dv%0d", j), 32'(dv_a), 32'd1);
         chk($sformatf("skid_dat%0d", j), 32'(dat_a),
             (j <= 8) ? 32'(w1[8-j]) : 32'(w2[16-j]));
         chk($sformatf("skid_rdy%0d", j), 32'(rdy_a),
             32'(j == 1 || j >= 9));
         tick();
      end
      chk("skid_end_dv", 32'(dv_a), 32'd0);
`else
      for (int j = 1; j <= 17; j++) begin
         if (j == 10) lv_a = 1'b0;
         if (j == 9) begin
            chk("b2b_gap_dv", 32'(dv_a), 32'd0);
            chk("b2b_gap_rdy", 32'(rdy_a), 32'd1);
         end else begin
            chk($sformatf("b2b_dv%0d", j), 32'(dv_a), 32'd1);
            chk($sformatf("b2b_rdy%0d", j), 32'(rdy_a), 32'd0);
            chk($sformatf("b2b_dat%0d", j), 32'(dat_a),
                (j <= 8) ? 32'(w1[8-j]) : 32'(w2[17-j]));
         end
         tick();
      end
      chk("b2b_end_dv", 32'(dv_a), 32'd0);
`endif
      lv_a = 1'b0;
      en_a = 1'b0;

      // 32-bit loopback
      sclr_b = 1'b1;
      tick();
      sclr_b = 1'b0;
      lv_b   = 1'b1;
      data_b = 32'hDEADBEEF;
      tick();
      lv_b   = 1'b0;
      data_b = '0;
      got_n  = 0;
      k = 0;
      while (dv_b && k < 100) begin
         en_b = (k % 5) != 3;
         if (en_b) got_n++;
         tick();
         k++;
      end
      en_b = 1'b0;
      chk("lb_timeout", 32'(k < 100), 32'd1);
      chk("lb_strobes", 32'(got_n), 32'd32);
      chk("lb_rx", rx_b, 32'hDEADBEEF);
      chk("lb_rdy", 32'(rdy_b), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
